// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB PID constants and transmit scheduler state encoding
package usb_pkg;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_START,
    ST_HS_WAIT,
    ST_D_START,
    ST_D_BYTE,
    ST_D_WAIT,
    ST_ACK_WAIT
  } tx_sched_state_t;

endpackage

// File: rtl/usb_tx_payload_mux.sv
// rtl/usb_tx_payload_mux.sv - nonce result register, byte index and payload byte selection
module usb_tx_payload_mux #(
  parameter int NONCE_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     capture_i,
  input  logic [8*NONCE_BYTES-1:0] nonce_i,
  input  logic                     idx_clr_i,
  input  logic                     idx_inc_i,
  input  logic                     data_en_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_last_o
);

  localparam int IDX_W = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;

  logic [8*NONCE_BYTES-1:0] result_q, result_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]               cur_byte;
  logic                     last_byte;

  // Next result and index: capture gating is decided by the scheduler.
  always_comb begin
    result_d   = capture_i ? nonce_i : result_q;
    byte_idx_d = byte_idx_q;
    if (idx_clr_i) begin
      byte_idx_d = '0;
    end else if (idx_inc_i) begin
      byte_idx_d = byte_idx_q + 1'b1;
    end
  end

  // Result and byte index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result_q   <= '0;
      byte_idx_q <= '0;
    end else begin
      result_q   <= result_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Payload goes out LSB first; outputs read zero outside the byte phase.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NONCE_BYTES; i++) begin
      if (byte_idx_q == IDX_W'(i)) begin
        cur_byte = result_q[8*i +: 8];
      end
    end
    last_byte = (byte_idx_q == IDX_W'(NONCE_BYTES - 1));
    tx_data_o = data_en_i ? cur_byte : 8'h00;
    tx_last_o = data_en_i & last_byte;
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - USB TX encoder scheduler; USB_TX_STATS_EN adds event counters
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int NONCE_BYTES = 4,
  parameter int ACK_TIMEOUT = 64
`ifdef USB_TX_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     transmit_ack,
  input  logic                     transmit_nack,
  input  logic                     host_ready,
  input  logic                     hash_done,
  input  logic [8*NONCE_BYTES-1:0] nonce,
  input  logic                     host_ack,
  output logic                     tx_start,
  output logic [7:0]               tx_pid,
  output logic [7:0]               tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_data_ready,
  output logic                     tx_last,
  input  logic                     tx_done,
  output logic                     result_pending,
  output logic                     result_overrun,
  output logic                     busy
`ifdef USB_TX_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_hs_cnt,
  output logic [STAT_W-1:0]        stat_data_cnt,
  output logic [STAT_W-1:0]        stat_timeout_cnt
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

  tx_sched_state_t  state_q, state_d;
  logic             nack_req_q, nack_req_d, nack_clr;
  logic             ack_req_q, ack_req_d, ack_clr;
  logic             in_req_q, in_req_d, in_clr;
  logic             pending_q, pending_d, pending_clr;
  logic             toggle_q, toggle_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       pid_q, pid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture_ok, capture;
  logic             idx_clr, idx_inc;

  // Request latches (set wins over clear), result capture window and overrun detect.
  always_comb begin
    nack_req_d = transmit_nack | (nack_req_q & ~nack_clr);
    ack_req_d  = transmit_ack  | (ack_req_q  & ~ack_clr);
    in_req_d   = host_ready    | (in_req_q   & ~in_clr);
    capture_ok = (state_q == ST_IDLE) || (state_q == ST_HS_START) || (state_q == ST_HS_WAIT);
    capture    = hash_done & capture_ok;
    overrun_d  = hash_done & ~capture_ok;
    pending_d  = capture | (pending_q & ~pending_clr);
  end

  // Next-state logic: arbitration in IDLE, packet sequencing, host ACK wait with timeout.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    toggle_d    = toggle_q;
    cnt_d       = cnt_q;
    nack_clr    = 1'b0;
    ack_clr     = 1'b0;
    in_clr      = 1'b0;
    pending_clr = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nack_req_q) begin
          nack_clr = 1'b1;
          pid_d    = PID_NAK;
          state_d  = ST_HS_START;
        end else if (ack_req_q) begin
          ack_clr = 1'b1;
          pid_d   = PID_ACK;
          state_d = ST_HS_START;
        end else if (in_req_q) begin
          in_clr = 1'b1;
          if (pending_q) begin
            pid_d   = toggle_q ? PID_DATA1 : PID_DATA0;
            state_d = ST_D_START;
          end else begin
            pid_d   = PID_NAK;
            state_d = ST_HS_START;
          end
        end
      end
      ST_HS_START: state_d = ST_HS_WAIT;
      ST_HS_WAIT: begin
        if (tx_done) state_d = ST_IDLE;
      end
      ST_D_START: begin
        idx_clr = 1'b1;
        state_d = ST_D_BYTE;
      end
      ST_D_BYTE: begin
        if (tx_data_ready) begin
          if (tx_last) state_d = ST_D_WAIT;
          else         idx_inc = 1'b1;
        end
      end
      ST_D_WAIT: begin
        cnt_d = '0;
        if (tx_done) state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (host_ack) begin
          toggle_d    = ~toggle_q;
          pending_clr = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q == TIMEOUT_VAL) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      nack_req_q <= 1'b0;
      ack_req_q  <= 1'b0;
      in_req_q   <= 1'b0;
      pending_q  <= 1'b0;
      toggle_q   <= 1'b0;
      overrun_q  <= 1'b0;
      pid_q      <= 8'h00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      nack_req_q <= nack_req_d;
      ack_req_q  <= ack_req_d;
      in_req_q   <= in_req_d;
      pending_q  <= pending_d;
      toggle_q   <= toggle_d;
      overrun_q  <= overrun_d;
      pid_q      <= pid_d;
      cnt_q      <= cnt_d;
    end
  end

  usb_tx_payload_mux #(
    .NONCE_BYTES(NONCE_BYTES)
  ) u_payload (
    .clk      (clk),
    .n_rst    (n_rst),
    .capture_i(capture),
    .nonce_i  (nonce),
    .idx_clr_i(idx_clr),
    .idx_inc_i(idx_inc),
    .data_en_i(tx_data_valid),
    .tx_data_o(tx_data),
    .tx_last_o(tx_last)
  );

  assign tx_start       = (state_q == ST_HS_START) || (state_q == ST_D_START);
  assign tx_data_valid  = (state_q == ST_D_BYTE);
  assign busy           = (state_q != ST_IDLE);
  assign tx_pid         = pid_q;
  assign result_pending = pending_q;
  assign result_overrun = overrun_q;

`ifdef USB_TX_STATS_EN
  logic [STAT_W-1:0] hs_cnt_q, data_cnt_q, to_cnt_q;
  logic              timeout_hit;

  assign timeout_hit = (state_q == ST_ACK_WAIT) && !host_ack && (cnt_q == TIMEOUT_VAL);

  // Saturating event counters; each START state lasts exactly one cycle per entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hs_cnt_q   <= '0;
      data_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      if ((state_q == ST_HS_START) && (hs_cnt_q != '1)) hs_cnt_q <= hs_cnt_q + 1'b1;
      if ((state_q == ST_D_START) && (data_cnt_q != '1)) data_cnt_q <= data_cnt_q + 1'b1;
      if (timeout_hit && (to_cnt_q != '1)) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign stat_hs_cnt      = hs_cnt_q;
  assign stat_data_cnt    = data_cnt_q;
  assign stat_timeout_cnt = to_cnt_q;
`endif

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - scoreboard bench for usb_tx_scheduler with encoder/host models
module tb_usb_tx_scheduler;

  localparam int NB = 4;
  localparam int TO = 64;
  localparam logic [7:0] E_ACK = 8'hD2, E_NAK = 8'h5A, E_D0 = 8'hC3, E_D1 = 8'h4B;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          transmit_ack, transmit_nack, host_ready, hash_done, host_ack;
  logic [8*NB-1:0] nonce;
  logic          tx_start, tx_data_valid, tx_data_ready, tx_last, tx_done;
  logic [7:0]    tx_pid, tx_data;
  logic          result_pending, result_overrun, busy;
`ifdef USB_TX_STATS_EN
  logic [15:0]   stat_hs_cnt, stat_data_cnt, stat_timeout_cnt;
`endif

  always #5 clk = ~clk;

  usb_tx_scheduler #(.NONCE_BYTES(NB), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .transmit_ack(transmit_ack), .transmit_nack(transmit_nack),
    .host_ready(host_ready), .hash_done(hash_done), .nonce(nonce), .host_ack(host_ack),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .tx_last(tx_last), .tx_done(tx_done),
    .result_pending(result_pending), .result_overrun(result_overrun), .busy(busy)
`ifdef USB_TX_STATS_EN
    , .stat_hs_cnt(stat_hs_cnt), .stat_data_cnt(stat_data_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  pid;
    bit          is_data;
    logic [63:0] bytes;
  } pkt_t;

  pkt_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_cnt = 0;
  bit          m_pending, m_toggle;
  logic [63:0] m_result;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every packet start and checks the payload stream.
  initial begin : monitor
    pkt_t        cur;
    bit          collecting;
    bit          prev_stall;
    int          idx;
    logic [7:0]  prev_data;
    logic [63:0] sh;
    collecting = 0; prev_stall = 0; idx = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        collecting = 0;
        prev_stall = 0;
        exp_q.delete();
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", tx_data_valid, 1);
          chk("stall_data_stable", tx_data, prev_data);
        end
        if (tx_start) begin
          chk("prev_packet_complete", collecting, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start: pid %0h with empty scoreboard", tx_pid);
            collecting = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("pid", tx_pid, cur.pid);
            collecting = cur.is_data;
            idx = 0;
          end
        end
        if (tx_data_valid && tx_data_ready) begin
          chk("byte_in_data_packet", collecting, 1);
          if (collecting) begin
            sh = cur.bytes >> (8 * idx);
            chk($sformatf("byte%0d", idx), tx_data, sh[7:0]);
            chk("tx_last", tx_last, (idx == NB - 1));
            idx++;
            if (idx == NB) collecting = 0;
          end
        end
        prev_stall = tx_data_valid && !tx_data_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Encoder model: random ready with optional forced stall, tx_done a few cycles after EOP.
  initial begin : encoder
    int cd;
    bit cd_on, fin;
    cd = 0; cd_on = 0; fin = 0;
    tx_data_ready = 0;
    tx_done = 0;
    forever begin
      step();
      tx_done = 0;
      if (!n_rst) begin
        cd_on = 0;
        fin = 0;
        tx_data_ready = 0;
      end else begin
        if (fin) begin
          cd_on = 1;
          cd = $urandom_range(0, 3);
          fin = 0;
        end
        if (cd_on) begin
          if (cd == 0) begin
            tx_done = 1;
            cd_on = 0;
          end else begin
            cd--;
          end
        end
        if (tx_start && (tx_pid == E_ACK || tx_pid == E_NAK)) begin
          cd_on = 1;
          cd = $urandom_range(0, 3);
        end
        if (stall_cnt > 0 && tx_data_valid) begin
          tx_data_ready = 0;
          stall_cnt--;
        end else begin
          tx_data_ready = ($urandom_range(0, 3) != 0);
        end
        fin = tx_data_valid && tx_data_ready && tx_last;
      end
    end
  end

  task automatic wait_idle();
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk("idle_within_bound", (quiet >= 4), 1);
    step();
  endtask

  task automatic send_hs(input bit a, input bit nk);
    pkt_t p;
    p.is_data = 0;
    p.bytes = 0;
    if (nk) begin p.pid = E_NAK; exp_q.push_back(p); end
    if (a)  begin p.pid = E_ACK; exp_q.push_back(p); end
    transmit_ack = a;
    transmit_nack = nk;
    step();
    transmit_ack = 0;
    transmit_nack = 0;
    wait_idle();
  endtask

  task automatic send_hash(input logic [31:0] v);
    hash_done = 1;
    nonce = v;
    step();
    hash_done = 0;
    m_result = {32'h0, v};
    m_pending = 1;
    @(negedge clk);
    chk("pending_after_hash", result_pending, m_pending);
    step();
  endtask

  task automatic push_in_expect(output bit is_data);
    pkt_t p;
    if (m_pending) begin
      p.pid = m_toggle ? E_D1 : E_D0;
      p.is_data = 1;
      p.bytes = m_result;
    end else begin
      p.pid = E_NAK;
      p.is_data = 0;
      p.bytes = 0;
    end
    is_data = p.is_data;
    exp_q.push_back(p);
  endtask

  // Waits for the data packet EOP, then plays the host: ACK after d cycles of ACK_WAIT, or none.
  task automatic finish_data(input bit do_ack, input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("data_done_seen", tx_done, 1);
    step();
    if (do_ack) begin
      repeat (d) step();
      host_ack = 1;
      step();
      host_ack = 0;
      if (d <= TO) begin
        m_toggle = ~m_toggle;
        m_pending = 0;
      end
    end
  endtask

  task automatic send_in(input bit do_ack, input int d, input int stall);
    bit is_data;
    stall_cnt = stall;
    push_in_expect(is_data);
    host_ready = 1;
    step();
    host_ready = 0;
    if (is_data) finish_data(do_ack, d);
    wait_idle();
    chk("pending_after_in", result_pending, m_pending);
  endtask

  task automatic reach_d_byte(input int stall);
    bit is_data;
    int n;
    stall_cnt = stall;
    push_in_expect(is_data);
    host_ready = 1;
    step();
    host_ready = 0;
    n = 0;
    @(negedge clk);
    while (!tx_data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_d_byte", tx_data_valid, 1);
    step();
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {tx_start, tx_pid, tx_data, tx_data_valid, tx_last, result_pending, result_overrun, busy}, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    n_rst = 0;
    transmit_ack = 0; transmit_nack = 0; host_ready = 0; hash_done = 0; host_ack = 0; nonce = 0;
    m_pending = 0; m_toggle = 0; m_result = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    step();
    n_rst = 1;
    step();

    // Handshake latency: pulse sampled in cycle N, tx_start in N+2, idle the cycle after tx_done.
    exp_q.push_back('{pid: E_ACK, is_data: 0, bytes: 0});
    transmit_ack = 1;
    @(negedge clk);
    step();
    transmit_ack = 0;
    @(negedge clk);
    chk("latency_no_start_n1", tx_start, 0);
    @(negedge clk);
    chk("latency_start_n2", tx_start, 1);
    chk("latency_pid", tx_pid, E_ACK);
    n = 0;
    while (!tx_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hs_done_seen", tx_done, 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    step();
    wait_idle();

    send_hs(1, 1);
    send_in(1, 0, 0);
    send_hash(32'hDEADBEEF);
    send_in(1, 3, 0);
    send_hash(32'h12345678);
    send_in(0, 0, 5);
    send_in(1, TO, 0);
    send_hash(32'hCAFEF00D);
    send_in(1, TO + 1, 2);
    send_in(1, 0, 0);

    // Overrun: a nonce arriving mid-transfer is dropped and the payload is unchanged.
    send_hash(32'hA5A55A5A);
    reach_d_byte(3);
    hash_done = 1;
    nonce = 32'h0BADF00D;
    step();
    hash_done = 0;
    @(negedge clk);
    chk("overrun_pulse", result_overrun, 1);
    @(negedge clk);
    chk("overrun_one_cycle", result_overrun, 0);
    finish_data(1, 2);
    wait_idle();
    chk("pending_after_overrun_txn", result_pending, m_pending);

    // Reset in the middle of the payload phase.
    send_hash(32'h01020304);
    reach_d_byte(4);
    n_rst = 0;
    stall_cnt = 0;
    m_pending = 0; m_toggle = 0; m_result = 0;
    @(negedge clk);
    check_reset_outputs("reset_mid_packet");
    step();
    n_rst = 1;
    step();
    wait_idle();
    send_hash(32'h55667788);
    send_in(1, 1, 0);

    for (int it = 0; it < 40; it++) begin
      int r;
      case ($urandom_range(0, 3))
        0: send_hash($urandom);
        1: send_hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          r = $urandom_range(0, 9);
          send_in(r != 0, (r == 1) ? $urandom_range(60, 70) : $urandom_range(0, 20), $urandom_range(0, 6));
        end
      endcase
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
